seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/shift_pkg.sv | 10 +
 rtl/shift_step.sv | 19 +
 rtl/seq_shifter.sv | 54 +++++
 tb/tb_seq_shifter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: op encodings, FSM states and default sizes for seq_shifter.
package shift_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP = 4;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift of amt bits for the selected op.
module shift_step import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] ar;
  always_comb begin
    ar = $signed(d) >>> amt;
    q = op == OP_SLL ? d << amt :
        op == OP_SRL ? d >> amt :
        op == OP_SRA ? ar :
        (d << amt) | (d >> (WIDTH - int'(amt)));
  end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter moving at most STEP bits per clock.
module seq_shifter import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP = DEF_STEP,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);
  localparam logic [SHW:0] STEP_W = STEP[SHW:0];
  state_t st, nxt;
  logic [1:0] op_r;
  logic [SHW-1:0] rem, amt;
  logic [WIDTH-1:0] stepped;
  logic accept;
  always_comb begin
    accept = start && st != SHIFT;
    amt = ({1'b0, rem} < STEP_W) ? rem : STEP_W[SHW-1:0];
  end
  shift_step #(.WIDTH(WIDTH)) u_step (.op(op_r), .d(dout), .amt(amt), .q(stepped));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = IDLE;
    if (accept) nxt = shamt == '0 ? DONE : SHIFT;
    else if (st == SHIFT) nxt = rem == amt ? DONE : SHIFT;
  end
  always_comb begin
    busy = st == SHIFT;
    done = st == DONE;
  end
  // dout doubles as the working register; it only settles once DONE is reached
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_r <= OP_SLL;
      dout <= '0;
      rem <= '0;
    end else if (accept) begin
      op_r <= op;
      dout <= din;
      rem <= shamt;
    end else if (st == SHIFT) begin
      dout <= stepped;
      rem <= rem - amt;
    end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed and random checks of seq_shifter against a bit-serial model.
module tb_seq_shifter;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] op = 0;
  logic [31:0] din = 0;
  logic [4:0] shamt = 0;
  logic busy, done;
  logic [31:0] dout;
  int errs = 0, checks = 0;
  seq_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .din(din),
    .shamt(shamt), .busy(busy), .done(done), .dout(dout));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
    logic [31:0] r = d;
    for (int i = 0; i < s; i++)
      r = o == 2'd0 ? {r[30:0], 1'b0} : o == 2'd1 ? {1'b0, r[31:1]} :
          o == 2'd2 ? {r[31], r[31:1]} : {r[30:0], r[31]};
    return r;
  endfunction
  function automatic int lat(input int s);
    return s == 0 ? 1 : 1 + (s + 3) / 4;
  endfunction
  // drive a request, return in the DONE cycle after checking latency, busy span and result
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] d, input int s);
    int cyc, nb;
    @(negedge clk);
    start = 1; op = o; din = d; shamt = 5'(s);
    @(negedge clk);
    start = 0; din = $urandom; op = 2'($urandom);
    cyc = 1; nb = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat(s)));
    chk({tag, "_busy"}, 64'(nb), 64'(lat(s) - 1));
    chk({tag, "_both"}, 64'(busy), 64'd0);
    chk({tag, "_dout"}, 64'(dout), 64'(model(o, d, s)));
  endtask
  initial begin
    logic [1:0] ro;
    logic [31:0] rd;
    int rs, cyc;
    bit seen;
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_dout", 64'(dout), 0);
    @(negedge clk);
    rst_n = 1;
    run("sll31", 2'd0, 32'h0000_0001, 31);
    chk("sll31_val", 64'(dout), 64'h8000_0000);
    run("sra4", 2'd2, 32'h8000_0000, 4);
    chk("sra4_val", 64'(dout), 64'hF800_0000);
    run("srl4", 2'd1, 32'h8000_0000, 4);
    chk("srl4_val", 64'(dout), 64'h0800_0000);
    run("rotl5", 2'd3, 32'h8000_0001, 5);
    chk("rotl5_val", 64'(dout), 64'h0000_0030);
    for (int o = 0; o < 4; o++) run("zero", 2'(o), 32'hDEAD_BEEF, 0);
    run("rotl31", 2'd3, 32'h1234_5678, 31);
    run("sra_pos", 2'd2, 32'h7000_0000, 7);
    @(negedge clk);
    chk("hold_dout", 64'(dout), 64'(model(2'd2, 32'h7000_0000, 7)));
    // start ignored mid-shift, then back-to-back from DONE
    @(negedge clk);
    start = 1; op = 2'd0; din = 32'h1; shamt = 5'd8;
    @(negedge clk);
    op = 2'd2; din = 32'hFFFF_FFFF; shamt = 5'd1;
    @(negedge clk);
    start = 0;
    cyc = 2;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("ign_lat", 64'(cyc), 64'd3);
    chk("ign_dout", 64'(dout), 64'h0000_0100);
    start = 1; op = 2'd3; din = 32'h8000_0001; shamt = 5'd5;
    @(negedge clk);
    start = 0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done", 64'(done), 64'd0);
    cyc = 1;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("b2b_lat", 64'(cyc), 64'd3);
    chk("b2b_dout", 64'(dout), 64'h0000_0030);
    // reset in the middle of an 8-cycle shift
    @(negedge clk);
    start = 1; op = 2'd0; din = 32'hFFFF_FFFF; shamt = 5'd31;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_done", 64'(done), 0);
    chk("arst_dout", 64'(dout), 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("arst_nopulse", 64'(seen), 0);
    // first start is sampled on the first edge after release
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; start = 1; op = 2'd1; din = 32'hF000_0000; shamt = 5'd3;
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("first_lat", 64'(cyc), 64'd2);
    chk("first_dout", 64'(dout), 64'h1E00_0000);
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rd = $urandom;
      rs = int'($urandom_range(0, 31));
      run("rnd", ro, rd, rs);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
